// File: rtl/csr_register_bank_if.sv
// rtl/csr_register_bank_if.sv - core CSR bus: write/read strobes, addresses, op, data, OR-combined read return
//   master: drives strobes, addresses, op and write data; receives csrReadData/csrRequestOutput
//   slave : receives strobes, addresses, op and write data; drives csrReadData/csrRequestOutput
interface csr_register_bank_if;
    logic        csrWriteEnable;
    logic        csrReadEnable;
    logic [11:0] csrWriteAddress;
    logic [11:0] csrReadAddress;
    logic [1:0]  csrWriteOp;
    logic [31:0] csrWriteData;
    logic [31:0] csrReadData;
    logic        csrRequestOutput;

    modport master (
        output csrWriteEnable, csrReadEnable, csrWriteAddress, csrReadAddress,
               csrWriteOp, csrWriteData,
        input  csrReadData, csrRequestOutput
    );

    modport slave (
        input  csrWriteEnable, csrReadEnable, csrWriteAddress, csrReadAddress,
               csrWriteOp, csrWriteData,
        output csrReadData, csrRequestOutput
    );
endinterface

// File: rtl/csr_register_bank.sv
// rtl/csr_register_bank.sv - bank of NUM_REGS 32-bit CSRs with write/set/clear, writable masks and sticky hw bits
//   clk, rst     : clock, synchronous active-high reset
//   bus          : CSR bus slave (write/read strobes, addresses, op, data, read return)
//   hwSet        : per-bit hardware set requests, 32 bits per register
//   values       : current register contents, register i at [32i+31:32i]
//   writePulse   : one-cycle strobe per register after an accepted software write
//   writeIgnored : one-cycle strobe after a write to a read-only (address[11:10]==11) bank
module csr_register_bank #(
    parameter logic [11:0]            BASE_ADDRESS = 12'h000,
    parameter int                     NUM_REGS     = 4,
    parameter logic [32*NUM_REGS-1:0] DEFAULTS     = {NUM_REGS{32'b0}},
    parameter logic [32*NUM_REGS-1:0] WRITE_MASK   = {NUM_REGS{32'hFFFFFFFF}},
    parameter logic [32*NUM_REGS-1:0] STICKY_MASK  = {NUM_REGS{32'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    csr_register_bank_if.slave       bus,
    input  logic [32*NUM_REGS-1:0]   hwSet,
    output logic [32*NUM_REGS-1:0]   values,
    output logic [NUM_REGS-1:0]      writePulse,
    output logic                     writeIgnored
);
    localparam int LAST_ADDRESS = int'(BASE_ADDRESS) + NUM_REGS - 1;
    // The CSR address space marks [11:10]==2'b11 as read-only.
    localparam bit READ_ONLY    = (BASE_ADDRESS[11:10] == 2'b11);

    if (NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_num_regs
        $error("csr_register_bank: NUM_REGS must be 1..16");
    end
    if (LAST_ADDRESS > 12'hFFF) begin : g_bad_range
        $error("csr_register_bank: register range runs past 12'hFFF");
    end else if ((LAST_ADDRESS >> 10) != int'(BASE_ADDRESS[11:10])) begin : g_bad_span
        $error("csr_register_bank: registers straddle an address[11:10] boundary");
    end

    logic [NUM_REGS-1:0][31:0] regQ;
    logic [NUM_REGS-1:0][31:0] regNext;
    logic [NUM_REGS-1:0]       writeHit;
    logic [NUM_REGS-1:0]       readHit;
    logic [NUM_REGS-1:0]       writeAccept;
    logic                      opValid;

    assign opValid     = (bus.csrWriteOp != 2'b11);
    assign writeAccept = writeHit & {NUM_REGS{opValid && !READ_ONLY}};
    assign values      = regQ;

    always_comb begin
        writeHit = '0;
        readHit  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            writeHit[i] = bus.csrWriteEnable && (bus.csrWriteAddress == BASE_ADDRESS + 12'(i));
            readHit[i]  = bus.csrReadEnable  && (bus.csrReadAddress  == BASE_ADDRESS + 12'(i));
        end
    end

    // Software operation first, then sticky hardware sets on top so hwSet
    // wins over a same-cycle clear or write-0 of the same bit.
    always_comb begin
        regNext = regQ;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (writeAccept[i]) begin
                case (bus.csrWriteOp)
                    2'b00:   regNext[i] = (regQ[i] & ~WRITE_MASK[32*i +: 32])
                                        | (bus.csrWriteData & WRITE_MASK[32*i +: 32]);
                    2'b01:   regNext[i] = regQ[i] | (bus.csrWriteData & WRITE_MASK[32*i +: 32]);
                    2'b10:   regNext[i] = regQ[i] & ~(bus.csrWriteData & WRITE_MASK[32*i +: 32]);
                    default: regNext[i] = regQ[i];
                endcase
            end
            regNext[i] = regNext[i] | (hwSet[32*i +: 32] & STICKY_MASK[32*i +: 32]);
        end
    end

    // Read return is zero when not selected so the core can OR slaves together.
    always_comb begin
        bus.csrReadData = 32'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (readHit[i]) begin
                bus.csrReadData = bus.csrReadData | regQ[i];
            end
        end
        bus.csrRequestOutput = |readHit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regQ         <= DEFAULTS;
            writePulse   <= '0;
            writeIgnored <= 1'b0;
        end else begin
            regQ         <= regNext;
            writePulse   <= writeAccept;
            writeIgnored <= READ_ONLY && opValid && (|writeHit);
        end
    end
endmodule
